// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: a small FIFO of DEPTH entries with a
// valid/ready handshake on both sides, 1-cycle latency and synchronous flush.
// in_ready and out_valid are flops, so neither side has a combinational path
// to the other.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake, in_data payload
//   out_valid/out_ready    downstream handshake, out_data head-of-queue payload
//   flush                  synchronous discard of all entries
//   count                  number of stored entries
module elastic_pipe_reg #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] FLUSH_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_inc, rd_inc;
  logic [PTR_W-1:0] wr_ptr_nxt, rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic             push_c, pop_c;

  assign push_c = in_valid & in_ready;
  assign pop_c  = out_valid & out_ready;

  // Pointer increments wrap explicitly so DEPTH need not be a power of two.
  assign wr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
  assign rd_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

  // Next-state: flush wins; otherwise apply push/pop and refresh the head copy.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    count_nxt    = count;
    out_data_nxt = out_data;
    if (flush) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
      out_data_nxt = FLUSH_VALUE;
    end else begin
      if (push_c) wr_ptr_nxt = wr_inc;
      if (pop_c)  rd_ptr_nxt = rd_inc;
      if (push_c && !pop_c) count_nxt = count + CNT_W'(1);
      if (pop_c && !push_c) count_nxt = count - CNT_W'(1);
      // Head changes on a pop (next stored entry, or the bypassed push when
      // the queue would otherwise drain) or on a push into an empty queue.
      // A pop that empties the queue leaves the last value in place.
      if (pop_c) begin
        if (count > CNT_W'(1))  out_data_nxt = mem[rd_inc];
        else if (push_c)        out_data_nxt = in_data;
      end else if (push_c && (count == '0)) begin
        out_data_nxt = in_data;
      end
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_data  <= RESET_VALUE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_data  <= out_data_nxt;
      in_ready  <= (count_nxt < CNT_W'(DEPTH));
      out_valid <= (count_nxt != '0);
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_c && !flush) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed and random checks of elastic_pipe_reg across three configurations.
module tb_elastic_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Instance A: DEPTH=2 with distinct reset/flush values
  logic        a_rst_n, a_iv, a_ir, a_ov, a_or, a_fl;
  logic [31:0] a_id, a_od;
  logic [1:0]  a_cnt;
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(2), .RESET_VALUE(32'h1234), .FLUSH_VALUE(32'hDEAD)) u_a (
    .clk(clk), .reset_n(a_rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
    .out_valid(a_ov), .out_ready(a_or), .out_data(a_od), .flush(a_fl), .count(a_cnt));

  // Instance B: DEPTH=3 streaming
  logic        rst_n, b_iv, b_ir, b_ov, b_or;
  logic [31:0] b_id, b_od;
  logic [1:0]  b_cnt;
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(3)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
    .out_valid(b_ov), .out_ready(b_or), .out_data(b_od), .flush(1'b0), .count(b_cnt));

  // Instance C: DEPTH=5 random traffic
  logic        c_iv, c_ir, c_ov, c_or;
  logic [31:0] c_id, c_od;
  logic [2:0]  c_cnt;
  elastic_pipe_reg #(.WIDTH(32), .DEPTH(5)) u_c (
    .clk(clk), .reset_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
    .out_valid(c_ov), .out_ready(c_or), .out_data(c_od), .flush(1'b0), .count(c_cnt));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] last_out;
  logic        m_push, m_pop;

  initial begin
    a_rst_n = 1'b0; rst_n = 1'b0;
    a_iv = 0; a_or = 0; a_fl = 0; a_id = '0;
    b_iv = 0; b_or = 0; b_id = '0;
    c_iv = 0; c_or = 0; c_id = '0;
    #12;
    check("rst_a_ov",  32'(a_ov),  32'd0);
    check("rst_a_ir",  32'(a_ir),  32'd1);
    check("rst_a_cnt", 32'(a_cnt), 32'd0);
    check("rst_a_od",  a_od,       32'h1234);
    check("rst_b_od",  b_od,       32'h0);
    a_rst_n = 1'b1; rst_n = 1'b1;

    // A: fill with A1, B2 while downstream stalls
    a_iv = 1; a_id = 32'hA1;
    tick();
    check("fill1_ov",  32'(a_ov),  32'd1);
    check("fill1_od",  a_od,       32'hA1);
    check("fill1_cnt", 32'(a_cnt), 32'd1);
    a_id = 32'hB2;
    tick();
    check("full_cnt", 32'(a_cnt), 32'd2);
    check("full_ir",  32'(a_ir),  32'd0);
    check("full_od",  a_od,       32'hA1);
    // drain with out_ready=1; in_ready must stay 0 while full
    a_iv = 0; a_or = 1;
    #1 check("full_ir_or1", 32'(a_ir), 32'd0);
    tick();
    check("drain1_od",  a_od,       32'hB2);
    check("drain1_cnt", 32'(a_cnt), 32'd1);
    check("drain1_ir",  32'(a_ir),  32'd1);
    tick();
    check("drain2_ov",  32'(a_ov),  32'd0);
    check("drain2_cnt", 32'(a_cnt), 32'd0);
    check("drain2_od",  a_od,       32'hB2);
    a_or = 0;

    // A: flush with a concurrent push of 0x55
    a_iv = 1; a_id = 32'h11;
    tick();
    a_id = 32'h22;
    tick();
    check("preflush_cnt", 32'(a_cnt), 32'd2);
    a_id = 32'h55; a_fl = 1;
    tick();
    a_fl = 0; a_iv = 0;
    check("flush_cnt", 32'(a_cnt), 32'd0);
    check("flush_ov",  32'(a_ov),  32'd0);
    check("flush_od",  a_od,       32'hDEAD);
    a_or = 1;
    tick();
    check("flush_ov2", 32'(a_ov), 32'd0);
    check("flush_od2", a_od,      32'hDEAD);
    a_or = 0;

    // A: async reset pulse between edges while count=1
    a_iv = 1; a_id = 32'h33;
    tick();
    a_iv = 0;
    check("prerst_cnt", 32'(a_cnt), 32'd1);
    #2 a_rst_n = 1'b0;
    #1;
    check("arst_ov",  32'(a_ov),  32'd0);
    check("arst_od",  a_od,       32'h1234);
    check("arst_cnt", 32'(a_cnt), 32'd0);
    check("arst_ir",  32'(a_ir),  32'd1);
    #1 a_rst_n = 1'b1;
    a_iv = 1; a_id = 32'h77;
    tick();
    a_iv = 0;
    check("postrst_ov", 32'(a_ov), 32'd1);
    check("postrst_od", a_od,      32'h77);

    // B: stream 0..9 with both sides always active
    b_iv = 1; b_or = 1;
    for (int i = 0; i < 10; i++) begin
      b_id = 32'(i);
      tick();
      check($sformatf("stream_od%0d", i), b_od, 32'(i));
      check($sformatf("stream_cnt%0d", i), 32'(b_cnt), 32'd1);
    end
    b_iv = 0;
    tick();
    check("stream_end_cnt", 32'(b_cnt), 32'd0);
    check("stream_end_od",  b_od,       32'd9);
    b_or = 0;

    // C: random traffic against a reference queue
    last_out = 32'h0;
    for (int n = 0; n < 10000; n++) begin
      check("rnd_ir",  32'(c_ir),  32'(q.size() < 5));
      check("rnd_ov",  32'(c_ov),  32'(q.size() != 0));
      check("rnd_cnt", 32'(c_cnt), 32'(q.size()));
      check("rnd_od",  c_od, (q.size() != 0) ? q[0] : last_out);
      c_iv = 1'($urandom_range(0, 1));
      c_or = 1'($urandom_range(0, 1));
      c_id = $urandom;
      m_push = c_iv && (q.size() < 5);
      m_pop  = c_or && (q.size() != 0);
      tick();
      if (m_pop) last_out = q.pop_front();
      if (m_push) q.push_back(c_id);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
ELASTIC_PIPE_REG -- requirements
Module: elastic_pipe_reg

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have a parameter DEPTH, default 2, giving the number of storage entries (legal range 1..16).
REQ-003 The block SHALL have a parameter RESET_VALUE, default 0, giving the out_data value after reset.
REQ-004 The block SHALL have a parameter FLUSH_VALUE, default 0, giving the out_data value after a flush.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit, an asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning the upstream stage presents data.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block can accept data this cycle.
REQ-009 The block SHALL have port in_data, input, WIDTH bits, the upstream payload.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning out_data holds the oldest stored entry.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the downstream stage consumes data this cycle.
REQ-012 The block SHALL have port out_data, output, WIDTH bits, the head-of-queue payload.
REQ-013 The block SHALL have port flush, input, 1 bit, a synchronous discard of all stored entries.
REQ-014 The block SHALL have port count, output, $clog2(DEPTH+1) bits, the number of stored entries.

Function
REQ-015 Push SHALL occur when in_valid & in_ready at a clock edge; pop SHALL occur when out_valid & out_ready at a clock edge.
REQ-016 in_ready SHALL equal (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-017 out_valid SHALL equal (count != 0), derived from registered state only, with no combinational path from in_valid.
REQ-018 Latency SHALL be 1 cycle: data pushed into an empty block appears on out_data with out_valid=1 in the next cycle.
REQ-019 Ordering SHALL be strict FIFO; entries SHALL never be duplicated or dropped except by flush or reset.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 When full (count==DEPTH), in_ready SHALL be 0 even if out_ready=1 in the same cycle; a pop SHALL make in_ready=1 in the following cycle.
REQ-022 Read and write pointers SHALL wrap from DEPTH-1 to 0; DEPTH SHALL NOT be required to be a power of two.
REQ-023 count SHALL increment by 1 on push-only, decrement by 1 on pop-only, and never exceed DEPTH or go below 0.
REQ-024 out_data SHALL update only when the head entry changes; after a pop that empties the block, out_data SHALL hold the last popped value.
REQ-025 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-026 flush=1 SHALL, at the clock edge, set count=0, reset both pointers to 0, and drive out_data=FLUSH_VALUE.
REQ-027 flush SHALL take priority over a same-cycle push or pop: incoming data is discarded, and the pop is not counted.
REQ-028 With DEPTH=1, in_ready and out_valid SHALL be mutually exclusive, giving half throughput as a plain handshaked register.

Reset
REQ-029 When reset_n=0, the block SHALL immediately, without waiting for clk, force count=0, out_valid=0, in_ready=1 (DEPTH>=1), out_data=RESET_VALUE, and pointers=0.
REQ-030 Reset asserted mid-operation SHALL discard all entries; the first push after release SHALL appear as the head with 1-cycle latency.
REQ-031 Storage array contents SHALL NOT require reset; only pointers, count and the out_data register are reset.

Verification
REQ-032 The bench SHALL cover: WIDTH=32, DEPTH=2, push 0xA1, then 0xB2 on consecutive cycles with out_ready=0 -> count=2, in_ready=0, out_data=0xA1.
REQ-033 The bench SHALL cover: from that full state, hold out_ready=1 for 2 cycles with in_valid=0 -> out_data 0xA1 then 0xB2, then out_valid=0, count=0, and out_data stays 0xB2.
REQ-034 The bench SHALL cover: DEPTH=3, continuous in_valid=1 and out_ready=1 for 10 cycles with incrementing data 0..9 -> after a 1-cycle fill, one pop per cycle with count=1 steady, and outputs 0..9 in order.
REQ-035 The bench SHALL cover: FLUSH_VALUE=0xDEAD, count=2, then flush=1 with in_valid=1 and in_data=0x55 -> next cycle count=0, out_valid=0, out_data=0xDEAD, and 0x55 never emerges.
REQ-036 The bench SHALL cover: RESET_VALUE=0x1234, with reset_n pulsed low between edges while count=1 -> out_valid=0 and out_data=0x1234 before the next edge; after release, push 0x77 -> out_data=0x77 one cycle later.
REQ-037 The bench SHALL cover: DEPTH=5, with random in_valid/out_ready for 10k cycles against a reference queue model -> no data mismatch, count never above 5, and no push accepted while in_ready=0.
